// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multi-cycle RV32I core: walks each instruction through
// IF/ID/EX/MEM/WB over a shared memory port and ALU, detects the ecall halt and counts retirements.
module multicycle_control_fsm #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 bcond,
    input  logic                 halt_cond,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_source,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 pc_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 is_halted,
    output logic [CNT_WIDTH-1:0] instret
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    // inIf and branchEx mark strobes that also depend on same-cycle mem_ready / bcond.
    typedef struct packed {
        logic       pcWrite;
        logic       pcSource;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
        logic       memToReg;
        logic       pcToReg;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       isHalted;
        logic       inIf;
        logic       branchEx;
    } ctrl_t;

    function automatic logic isExecOp(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
    endfunction

    function automatic ctrl_t decodeCtrl(input state_t st, input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_IF: begin
                c.memRead = 1'b1;
                c.inIf    = 1'b1;
            end
            S_ID: c.aluSrcB = 2'd2;
            S_EX: begin
                case (op)
                    OP_R: begin
                        c.aluSrcA = 1'b1;
                        c.aluOp   = 2'b10;
                    end
                    OP_I: begin
                        c.aluSrcA = 1'b1;
                        c.aluSrcB = 2'd2;
                        c.aluOp   = 2'b10;
                    end
                    OP_LOAD, OP_STORE: begin
                        c.aluSrcA = 1'b1;
                        c.aluSrcB = 2'd2;
                    end
                    OP_BRANCH: begin
                        c.aluSrcA  = 1'b1;
                        c.aluOp    = 2'b01;
                        c.pcSource = 1'b1;
                        c.branchEx = 1'b1;
                    end
                    OP_JAL: begin
                        c.pcWrite  = 1'b1;
                        c.pcSource = 1'b1;
                        c.regWrite = 1'b1;
                        c.pcToReg  = 1'b1;
                    end
                    OP_JALR: begin
                        c.aluSrcA  = 1'b1;
                        c.aluSrcB  = 2'd2;
                        c.pcWrite  = 1'b1;
                        c.regWrite = 1'b1;
                        c.pcToReg  = 1'b1;
                    end
                    default: c = '0;
                endcase
            end
            S_MEM: begin
                c.iOrD     = 1'b1;
                c.memRead  = (op == OP_LOAD);
                c.memWrite = (op == OP_STORE);
            end
            S_WB: begin
                c.regWrite = 1'b1;
                c.memToReg = (op == OP_LOAD);
            end
            S_HALT: c.isHalted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t                 r_state;
    ctrl_t                  r_ctrl;
    logic [CNT_WIDTH-1:0]   r_instret;
    state_t                 w_nextState;
    logic                   w_retire;
    logic                   w_run;

    always_comb begin
        w_nextState = S_IF;
        case (r_state)
            S_IF:   w_nextState = mem_ready ? S_ID : S_IF;
            S_ID: begin
                if (opcode == OP_ECALL)
                    w_nextState = halt_cond ? S_HALT : S_IF;
                else if (isExecOp(opcode))
                    w_nextState = S_EX;
            end
            S_EX: begin
                if (opcode == OP_R || opcode == OP_I)
                    w_nextState = S_WB;
                else if (opcode == OP_LOAD || opcode == OP_STORE)
                    w_nextState = S_MEM;
            end
            S_MEM: begin
                if (!mem_ready)
                    w_nextState = S_MEM;
                else if (opcode == OP_LOAD)
                    w_nextState = S_WB;
            end
            S_WB:   w_nextState = S_IF;
            S_HALT: w_nextState = S_HALT;
            default: w_nextState = S_IF;
        endcase
    end

    assign w_retire = (w_nextState == S_IF) && (r_state inside {S_ID, S_EX, S_MEM, S_WB});

    // Controls for the upcoming state are registered at the edge; reset preloads the IF set
    // so fetch can begin on the first cycle after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IF;
            r_ctrl    <= decodeCtrl(S_IF, 7'd0);
            r_instret <= '0;
        end else begin
            r_state <= w_nextState;
            r_ctrl  <= decodeCtrl(w_nextState, opcode);
            if (w_retire)
                r_instret <= r_instret + 1'b1;
        end
    end

    assign w_run      = !reset;
    assign pc_write   = w_run & (r_ctrl.pcWrite | (r_ctrl.inIf & mem_ready) | (r_ctrl.branchEx & bcond));
    assign pc_source  = w_run & r_ctrl.pcSource;
    assign i_or_d     = w_run & r_ctrl.iOrD;
    assign mem_read   = w_run & r_ctrl.memRead;
    assign mem_write  = w_run & r_ctrl.memWrite;
    assign ir_write   = w_run & r_ctrl.inIf & mem_ready;
    assign reg_write  = w_run & r_ctrl.regWrite;
    assign mem_to_reg = w_run & r_ctrl.memToReg;
    assign pc_to_reg  = w_run & r_ctrl.pcToReg;
    assign alu_src_a  = w_run & r_ctrl.aluSrcA;
    assign alu_src_b  = !w_run ? 2'd0 : (r_ctrl.inIf ? {1'b0, mem_ready} : r_ctrl.aluSrcB);
    assign alu_op     = w_run ? r_ctrl.aluOp : 2'd0;
    assign is_halted  = w_run & r_ctrl.isHalted;
    assign instret    = r_instret;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench for multicycle_control_fsm: each instruction is expanded into
// its per-cycle expected control outputs, queued, and compared by an independent monitor.
module tb_multicycle_control_fsm;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = 7'd0;
    logic          bcond = 1'b0;
    logic          halt_cond = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write;
    logic          reg_write, mem_to_reg, pc_to_reg, alu_src_a, is_halted;
    logic [1:0]    alu_src_b, alu_op;
    logic [CW-1:0] instret;

    multicycle_control_fsm #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_cond(halt_cond),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .is_halted(is_halted), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcWrite, pcSource, iOrD, memRead, memWrite, irWrite;
        logic       regWrite, memToReg, pcToReg, aluSrcA;
        logic [1:0] aluSrcB, aluOp;
        logic       isHalted;
    } ctrl_t;

    typedef struct packed {
        ctrl_t         ctrl;
        logic [CW-1:0] instret;
        logic [31:0]   tag;
    } exp_t;

    typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_ECALL, K_UNK} kind_e;

    exp_t          expQ[$];
    int            compared = 0;
    int            mismatched = 0;
    logic [CW-1:0] modelInstret = '0;

    function automatic logic [6:0] opOf(input kind_e k);
        case (k)
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_LD:    return 7'b0000011;
            K_ST:    return 7'b0100011;
            K_BR:    return 7'b1100011;
            K_JAL:   return 7'b1101111;
            K_JALR:  return 7'b1100111;
            K_ECALL: return 7'b1110011;
            default: return 7'b0110111;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock period: drive inputs, record what the outputs must be, advance to just after the edge.
    task automatic stepCycle(input logic mr, input logic bc, input logic hc, input ctrl_t c,
                             input logic [31:0] tag);
        exp_t e;
        mem_ready = mr;
        bcond     = bc;
        halt_cond = hc;
        e.ctrl    = c;
        e.instret = modelInstret;
        e.tag     = tag;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic retire();
        modelInstret = modelInstret + 1'b1;
    endtask

    // Asynchronous reset asserted mid-cycle: every output must be low before the next edge.
    task automatic doReset();
        exp_t e;
        mem_ready = rnd();
        #1;
        reset     = 1'b1;
        modelInstret = '0;
        e.ctrl    = '0;
        e.instret = '0;
        e.tag     = "RST";
        expQ.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic fetchPhase(input int stalls);
        ctrl_t c;
        for (int s = 0; s <= stalls; s++) begin
            c = '0;
            c.memRead = 1'b1;
            if (s == stalls) begin
                c.irWrite = 1'b1;
                c.pcWrite = 1'b1;
                c.aluSrcB = 2'd1;
            end
            stepCycle(s == stalls, rnd(), rnd(), c, "IF");
        end
    endtask

    task automatic applyStimulus(input kind_e k, input logic bc, input int fetchStalls,
                                 input int memStalls, input bit abortMem);
        ctrl_t c;
        opcode = opOf(k);
        fetchPhase(fetchStalls);
        c = '0;
        c.aluSrcB = 2'd2;
        stepCycle(rnd(), rnd(), (k == K_ECALL) ? 1'b0 : rnd(), c, "ID");
        if (k == K_ECALL || k == K_UNK) begin
            retire();
            return;
        end
        c = '0;
        case (k)
            K_R:    begin c.aluSrcA = 1; c.aluOp = 2'b10; end
            K_I:    begin c.aluSrcA = 1; c.aluSrcB = 2'd2; c.aluOp = 2'b10; end
            K_LD, K_ST: begin c.aluSrcA = 1; c.aluSrcB = 2'd2; end
            K_BR:   begin c.aluSrcA = 1; c.aluOp = 2'b01; c.pcSource = 1; c.pcWrite = bc; end
            K_JAL:  begin c.pcWrite = 1; c.pcSource = 1; c.regWrite = 1; c.pcToReg = 1; end
            K_JALR: begin c.aluSrcA = 1; c.aluSrcB = 2'd2; c.pcWrite = 1; c.regWrite = 1; c.pcToReg = 1; end
            default: c = '0;
        endcase
        stepCycle(rnd(), (k == K_BR) ? bc : rnd(), rnd(), c, "EX");
        if (k == K_BR || k == K_JAL || k == K_JALR) begin
            retire();
            return;
        end
        if (k == K_LD || k == K_ST) begin
            for (int s = 0; s <= memStalls; s++) begin
                if (abortMem && s == 1) begin
                    doReset();
                    return;
                end
                c = '0;
                c.iOrD     = 1'b1;
                c.memRead  = (k == K_LD);
                c.memWrite = (k == K_ST);
                stepCycle(s == memStalls, rnd(), rnd(), c, "MEM");
            end
            if (k == K_ST) begin
                retire();
                return;
            end
        end
        c = '0;
        c.regWrite = 1'b1;
        c.memToReg = (k == K_LD);
        stepCycle(rnd(), rnd(), rnd(), c, "WB");
        retire();
    endtask

    // ECALL with the halt flag set parks the core until reset, whatever the other inputs do.
    task automatic haltSequence(input int fetchStalls, input int holdCycles);
        ctrl_t c;
        opcode = opOf(K_ECALL);
        fetchPhase(fetchStalls);
        c = '0;
        c.aluSrcB = 2'd2;
        stepCycle(rnd(), rnd(), 1'b1, c, "ID");
        for (int i = 0; i < holdCycles; i++) begin
            c = '0;
            c.isHalted = 1'b1;
            opcode = 7'($urandom_range(0, 127));
            stepCycle(rnd(), rnd(), rnd(), c, "HALT");
        end
        doReset();
    endtask

    // Monitor: compares whatever the DUT shows mid-cycle against the oldest queued expectation.
    initial begin
        exp_t  e;
        ctrl_t obs;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                obs = '{pcWrite: pc_write, pcSource: pc_source, iOrD: i_or_d, memRead: mem_read,
                        memWrite: mem_write, irWrite: ir_write, regWrite: reg_write,
                        memToReg: mem_to_reg, pcToReg: pc_to_reg, aluSrcA: alu_src_a,
                        aluSrcB: alu_src_b, aluOp: alu_op, isHalted: is_halted};
                compared++;
                if (obs !== e.ctrl) begin
                    mismatched++;
                    $display("[TB] FAIL ctrl %s @%0t: got %b expected %b", e.tag, $time, obs, e.ctrl);
                end
                compared++;
                if (instret !== e.instret) begin
                    mismatched++;
                    $display("[TB] FAIL instret %s @%0t: got %0d expected %0d", e.tag, $time, instret, e.instret);
                end
            end
        end
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        @(posedge clk);
        #1;
        e.ctrl = '0;
        e.instret = '0;
        e.tag = "RST";
        expQ.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(K_R,     1'b0, 0, 0, 1'b0);
        applyStimulus(K_LD,    1'b0, 0, 2, 1'b0);
        applyStimulus(K_BR,    1'b1, 0, 0, 1'b0);
        applyStimulus(K_BR,    1'b0, 0, 0, 1'b0);
        applyStimulus(K_JAL,   1'b0, 0, 0, 1'b0);
        applyStimulus(K_JALR,  1'b0, 0, 0, 1'b0);
        applyStimulus(K_I,     1'b0, 1, 0, 1'b0);
        applyStimulus(K_ST,    1'b0, 2, 1, 1'b0);
        applyStimulus(K_ECALL, 1'b0, 0, 0, 1'b0);
        applyStimulus(K_UNK,   1'b0, 0, 0, 1'b0);
        applyStimulus(K_ST,    1'b0, 0, 2, 1'b1);
        applyStimulus(K_R,     1'b0, 0, 0, 1'b0);
        applyStimulus(K_LD,    1'b0, 1, 0, 1'b0);
        haltSequence(1, 20);

        for (int n = 0; n < 120; n++) begin
            applyStimulus(kind_e'($urandom_range(0, 8)), rnd(), $urandom_range(0, 2),
                          $urandom_range(0, 2), 1'b0);
        end
        haltSequence(0, 5);
        applyStimulus(K_JAL, 1'b0, 0, 0, 1'b0);

        @(posedge clk);
        #6;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore-style sequencer that drives the shared datapath of the multi-cycle RV32I core: one memory port and one ALU, plus IR, MDR, A, B, ALUOut, OLD_PC and PC registers.
- Steps each instruction through IF/ID/EX/MEM/WB and waits on a memory ready handshake.
- Detects the ecall halt condition and counts retired instructions.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
opcode  input  7  IR[6:0], stable from ID onward
bcond  input  1  ALU branch-condition result (valid in EX for branches)
halt_cond  input  1  datapath flag, x17 == 10
mem_ready  input  1  memory completes current access this cycle
pc_write  output  1  PC load strobe
pc_source  output  1  PC mux: 0 = live ALU result, 1 = ALUOut register
i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  latch IR and OLD_PC
reg_write  output  1  register file write enable
mem_to_reg  output  1  rd data: 1 = MDR, 0 = ALUOut
pc_to_reg  output  1  rd data = PC (overrides mem_to_reg)
alu_src_a  output  1  0 = PC/OLD_PC per state, 1 = A
alu_src_b  output  2  0 = B, 1 = const 4, 2 = immediate
alu_op  output  2  00 = add, 01 = branch compare, 10 = funct decode
is_halted  output  1  core halted
instret  output  CNT_WIDTH  retired instruction count

Behaviour:
- Reset behaviour:
  - On async reset: state = IF, instret = 0.
  - All outputs are 0 while reset is high; strobes are gated by !reset.
- State encoding: IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4, HALT = 5. Any other value goes to IF.
- Output defaults: every strobe is 0 and alu_src/alu_op are 0 unless listed below.
- IF:
  - mem_read = 1, i_or_d = 0.
  - Request is held until mem_ready.
  - In the mem_ready cycle: ir_write = 1, pc_write = 1, pc_source = 0, alu_src_a = 0 (PC), alu_src_b = 1, alu_op = 00, giving PC <- PC+4. Next state ID.
  - Without mem_ready: stay in IF; pc_write = 0, ir_write = 0.
- ID:
  - alu_src_a = 0 (OLD_PC), alu_src_b = 2, alu_op = 00; ALUOut <- OLD_PC+imm.
  - ECALL (1110011): HALT if halt_cond, else IF (retires).
  - Unknown opcode: IF (retires as nop).
  - All other opcodes go to EX.
- EX, by opcode:
  - R (0110011): alu_src_a = 1, alu_src_b = 0, alu_op = 10. Next WB.
  - I-arith (0010011): alu_src_a = 1, alu_src_b = 2, alu_op = 10. Next WB.
  - LOAD (0000011) / STORE (0100011): alu_src_a = 1, alu_src_b = 2, alu_op = 00. Next MEM.
  - BRANCH (1100011): alu_src_a = 1, alu_src_b = 0, alu_op = 01. pc_write = bcond, pc_source = 1. Next IF. Not taken keeps the PC+4 written in IF.
  - JAL (1101111): pc_write = 1, pc_source = 1, reg_write = 1, pc_to_reg = 1. rd receives the pre-edge PC (= OLD_PC+4). Next IF.
  - JALR (1100111): alu_src_a = 1, alu_src_b = 2, alu_op = 00, pc_write = 1, pc_source = 0, reg_write = 1, pc_to_reg = 1. Next IF.
- MEM:
  - i_or_d = 1; mem_read = 1 for LOAD, mem_write = 1 for STORE.
  - Strobes are held constant until mem_ready.
  - On mem_ready: LOAD goes to WB, STORE goes to IF (retires).
- WB: reg_write = 1, mem_to_reg = (opcode == LOAD). Next IF (retires).
- HALT: is_halted = 1, all strobes 0. State is held until reset.
- instret:
  - Increments by 1 on each edge that leaves ID, EX, MEM or WB toward IF.
  - Wraps modulo 2^CNT_WIDTH.
  - Does not increment on entry to HALT.
- Cycle counts with mem_ready constantly 1:
  - R / I-arith: 4.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH / JAL / JALR: 3.
  - ECALL (no halt): 2.
- Reset mid-operation (e.g., in MEM with mem_write = 1): mem_write drops immediately (asynchronous). After release, fetch restarts in IF.
- mem_ready outside IF/MEM is ignored.

Test Plan:
- ADD, mem_ready = 1 -> states IF, ID, EX, WB; reg_write = 1 and mem_to_reg = 0 in cycle 4; instret 0 -> 1 after 4 cycles.
- LW with mem_ready low for 2 cycles in MEM -> mem_read = 1, i_or_d = 1 held 3 cycles; WB with mem_to_reg = 1; total 7 cycles.
- BEQ with bcond = 1 -> EX pc_write = 1, pc_source = 1. With bcond = 0 -> EX pc_write = 0. Both take 3 cycles.
- JAL -> EX shows pc_write = reg_write = pc_to_reg = pc_source = 1. JALR -> same, except pc_source = 0 and alu_src_b = 2.
- ECALL with halt_cond = 1 -> HALT after ID, is_halted = 1 stays high 20 cycles, instret unchanged. With halt_cond = 0 -> IF after 2 cycles, instret +1.
- Assert reset during MEM of SW -> mem_write = 0 within the same cycle, instret = 0. After deassert, IF with mem_read = 1.
